// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: shared lane encodings, lane indices and game constants for the threat controller.
package nexys_starship_pkg;
    typedef enum logic [1:0] {EMPTY = 2'b00, ALIVE = 2'b01, COOL = 2'b10} lane_state_t;
    localparam int LANE_TOP   = 0;
    localparam int LANE_BTM   = 1;
    localparam int LANE_LEFT  = 2;
    localparam int LANE_RIGHT = 3;
    localparam int NUM_LANES  = 4;
    localparam logic [1:0] INIT_LIVES = 2'd3;
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction
endpackage

// File: rtl/nexys_starship_threat_lane.sv
// nexys_starship_threat_lane: one lane's EMPTY/ALIVE/COOL lifecycle with its lifetime/cooldown counter.
module nexys_starship_threat_lane
    import nexys_starship_pkg::*;
#(
    parameter int LIFETIME = 50000,
    parameter int COOLDOWN = 10000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic run,
    input  logic spawn,
    input  logic shoot,
    output logic monster,
    output logic kill_pulse,
    output logic damage_pulse,
    output logic kill_nxt,
    output logic damage_nxt
);
    lane_state_t state, state_nxt;
    logic [15:0] cnt, cnt_nxt;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        kill_nxt   = 1'b0;
        damage_nxt = 1'b0;
        if (!run) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else begin
            case (state)
                EMPTY: if (spawn) begin
                    state_nxt = ALIVE;
                    cnt_nxt   = 16'(LIFETIME - 1);
                end
                ALIVE: if (shoot || cnt == '0) begin
                    // a shot on the timeout cycle counts as a kill, never as damage
                    kill_nxt   = shoot;
                    damage_nxt = ~shoot;
                    state_nxt  = COOL;
                    cnt_nxt    = 16'(COOLDOWN - 1);
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
                COOL: begin
                    state_nxt = cnt == '0 ? EMPTY : COOL;
                    cnt_nxt   = cnt == '0 ? cnt : cnt - 16'd1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= EMPTY;
            cnt          <= '0;
            monster      <= 1'b0;
            kill_pulse   <= 1'b0;
            damage_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            monster      <= state_nxt == ALIVE;
            kill_pulse   <= kill_nxt;
            damage_pulse <= damage_nxt;
        end
    end
endmodule

// File: rtl/nexys_starship_threat_ctrl.sv
// nexys_starship_threat_ctrl: four monster lanes plus the score/lives bookkeeping.
module nexys_starship_threat_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int LIFETIME = 50000,
    parameter int COOLDOWN = 10000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       game_active,
    input  logic [3:0] spawn_req,
    input  logic [3:0] shoot,
    output logic [3:0] monster,
    output logic [3:0] kill_pulse,
    output logic [3:0] damage_pulse,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);
    logic       run;
    logic [3:0] kill_nxt, damage_nxt;
    logic [2:0] kills, hits;
    logic [8:0] score_sum;
    logic [1:0] lives_nxt;

    assign run = game_active & ~game_over;

    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            nexys_starship_threat_lane #(.LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN)) u_lane (
                .Clk          (Clk),
                .Reset        (Reset),
                .run          (run),
                .spawn        (spawn_req[i]),
                .shoot        (shoot[i]),
                .monster      (monster[i]),
                .kill_pulse   (kill_pulse[i]),
                .damage_pulse (damage_pulse[i]),
                .kill_nxt     (kill_nxt[i]),
                .damage_nxt   (damage_nxt[i])
            );
        end
    endgenerate

    // score/lives update on the same edge that raises the lane pulses
    always_comb begin
        kills     = popcount4(kill_nxt);
        hits      = popcount4(damage_nxt);
        score_sum = {1'b0, score} + 9'(kills);
        lives_nxt = {1'b0, lives} <= hits ? 2'd0 : lives - hits[1:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score     <= '0;
            lives     <= INIT_LIVES;
            game_over <= 1'b0;
        end else begin
            score     <= score_sum[8] ? 8'hFF : score_sum[7:0];
            lives     <= lives_nxt;
            game_over <= lives_nxt == 2'd0;
        end
    end
endmodule

// File: tb/tb_nexys_starship_threat_ctrl.sv
// tb_nexys_starship_threat_ctrl: directed and random scenarios checked against a lifetime/cooldown reference model.
module tb_nexys_starship_threat_ctrl;
    localparam int LIFETIME = 4;
    localparam int COOLDOWN = 2;

    logic       Clk, Reset, game_active;
    logic [3:0] spawn_req, shoot, monster, kill_pulse, damage_pulse;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;
    logic [22:0] obs;

    int total = 0, bad = 0;
    int al[4], cl[4];
    int m_score, m_lives;
    logic [3:0] m_kill, m_dmg;

    nexys_starship_threat_ctrl #(.LIFETIME(LIFETIME), .COOLDOWN(COOLDOWN)) dut (
        .Clk(Clk), .Reset(Reset), .game_active(game_active), .spawn_req(spawn_req),
        .shoot(shoot), .monster(monster), .kill_pulse(kill_pulse),
        .damage_pulse(damage_pulse), .score(score), .lives(lives), .game_over(game_over)
    );

    assign obs = {monster, kill_pulse, damage_pulse, score, lives, game_over};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [22:0] exp_v();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = al[i] > 0;
        return {m, m_kill, m_dmg, 8'(m_score), 2'(m_lives), m_lives == 0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin al[i] = 0; cl[i] = 0; end
        m_score = 0; m_lives = 3; m_kill = '0; m_dmg = '0;
    endtask

    // al = cycles of life left (0: no monster), cl = cooling cycles left
    task automatic model_step();
        bit run = game_active && m_lives != 0;
        m_kill = '0; m_dmg = '0;
        for (int i = 0; i < 4; i++) begin
            if (!run) begin al[i] = 0; cl[i] = 0; end
            else if (al[i] > 0) begin
                if (shoot[i]) begin m_kill[i] = 1; al[i] = 0; cl[i] = COOLDOWN; end
                else if (al[i] == 1) begin m_dmg[i] = 1; al[i] = 0; cl[i] = COOLDOWN; end
                else al[i]--;
            end
            else if (cl[i] > 0) cl[i]--;
            else if (spawn_req[i]) al[i] = LIFETIME;
        end
        m_score = m_score + $countones(m_kill);
        if (m_score > 255) m_score = 255;
        m_lives = m_lives - $countones(m_dmg);
        if (m_lives < 0) m_lives = 0;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic reset_on();
        Reset = 1'b1;
        #2;
        model_reset();
    endtask

    task automatic reset_off();
        Reset = 1'b0;
        game_active = 1'b1; spawn_req = '0; shoot = '0;
    endtask

    task automatic test_reset();
        reset_on();
        total++;
        if (obs !== 23'({4'h0, 4'h0, 4'h0, 8'h00, 2'd3, 1'b0})) begin
            bad++; $display("FAIL reset_vals got=%h exp=%h", obs, 23'({12'h0, 8'h00, 2'd3, 1'b0}));
        end
        reset_off();
        repeat (3) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, exp_v()); end
        end
    endtask

    task automatic test_spawn_timeout();
        int hi = 0, dm = 0, n = 0;
        reset_on(); reset_off();
        spawn_req = 4'b0001; tick(); spawn_req = '0;
        for (int c = 0; c < 10 && dm == 0; c++) begin
            total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL spawn_cyc%0d got=%h exp=%h", c, obs, exp_v()); end
            hi += monster[0];
            dm += damage_pulse[0];
            if (dm == 0) tick();
        end
        total++;
        if (hi != 4 || dm != 1 || lives !== 2'd2) begin
            bad++; $display("FAIL spawn_life got hi=%0d dm=%0d lives=%0d exp 4 1 2", hi, dm, lives);
        end
        spawn_req = 4'b0001;
        while (n < 8) begin
            tick(); n++; total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL respawn_cyc%0d got=%h exp=%h", n, obs, exp_v()); end
            if (monster[0]) break;
        end
        total++;
        if (n != 3) begin bad++; $display("FAIL respawn_delay got=%0d exp=3", n); end
        spawn_req = '0;
    endtask

    task automatic test_shoot_on_timeout();
        reset_on(); reset_off();
        spawn_req = 4'b0001; tick(); spawn_req = '0;
        repeat (3) tick();
        shoot = 4'b0001; tick(); shoot = '0;
        total++;
        if (obs !== exp_v()) begin bad++; $display("FAIL shot_timeout_model got=%h exp=%h", obs, exp_v()); end
        total++;
        if (kill_pulse !== 4'b0001 || damage_pulse !== 4'b0000 || score !== 8'd1 || lives !== 2'd3) begin
            bad++; $display("FAIL shot_timeout got k=%b d=%b s=%0d l=%0d exp k=0001 d=0000 s=1 l=3",
                            kill_pulse, damage_pulse, score, lives);
        end
        tick(); total++;
        if (obs !== exp_v()) begin bad++; $display("FAIL shot_after got=%h exp=%h", obs, exp_v()); end
    endtask

    task automatic test_all_timeout();
        reset_on(); reset_off();
        spawn_req = 4'b1111; tick(); spawn_req = '0;
        repeat (4) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL all_to got=%h exp=%h", obs, exp_v()); end
        end
        total++;
        if (damage_pulse !== 4'b1111 || lives !== 2'd0 || game_over !== 1'b1) begin
            bad++; $display("FAIL all_to_end got d=%b l=%0d go=%b exp 1111 0 1", damage_pulse, lives, game_over);
        end
        spawn_req = 4'b1111;
        repeat (8) begin
            tick(); total++;
            if (monster !== 4'b0000 || obs !== exp_v()) begin
                bad++; $display("FAIL over_spawn got=%h exp=%h", obs, exp_v());
            end
        end
        spawn_req = '0;
    endtask

    task automatic test_saturation();
        reset_on(); reset_off();
        spawn_req = 4'b1111; shoot = 4'b1111;
        repeat (300) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL sat got=%h exp=%h", obs, exp_v()); end
        end
        total++;
        if (score !== 8'd255) begin bad++; $display("FAIL sat_score got=%0d exp=255", score); end
        shoot = '0;
        repeat (12) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL cool_hold got=%h exp=%h", obs, exp_v()); end
        end
        spawn_req = '0;
    endtask

    task automatic test_pause();
        logic [7:0] s0;
        reset_on(); reset_off();
        spawn_req = 4'b0011; tick(); spawn_req = '0;
        shoot = 4'b0001; tick(); shoot = '0;
        s0 = score;
        spawn_req = 4'b0100; tick(); spawn_req = '0;
        total++;
        if (obs !== exp_v()) begin bad++; $display("FAIL pre_pause got=%h exp=%h", obs, exp_v()); end
        game_active = 1'b0; shoot = 4'b1111; tick();
        total++;
        if (monster !== 4'b0 || kill_pulse !== 4'b0 || damage_pulse !== 4'b0 || score !== s0 || lives !== 2'd3) begin
            bad++; $display("FAIL pause got=%h exp m=0 s=%0d l=3", obs, s0);
        end
        repeat (6) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL paused got=%h exp=%h", obs, exp_v()); end
        end
        game_active = 1'b1; shoot = '0; spawn_req = 4'b1000; tick(); spawn_req = '0;
        total++;
        if (obs !== exp_v() || score !== s0) begin bad++; $display("FAIL resume got=%h exp=%h", obs, exp_v()); end
    endtask

    task automatic test_reset_mid();
        reset_on(); reset_off();
        spawn_req = 4'b1010; tick(); spawn_req = '0;
        tick();
        total++;
        if (monster !== 4'b1010) begin bad++; $display("FAIL mid_alive got=%b exp=1010", monster); end
        shoot = 4'b1010;
        reset_on();
        total++;
        if (obs !== 23'({12'h0, 8'h00, 2'd3, 1'b0})) begin bad++; $display("FAIL mid_reset got=%h", obs); end
        tick(); total++;
        if (obs !== exp_v()) begin bad++; $display("FAIL mid_held got=%h exp=%h", obs, exp_v()); end
        reset_off();
        repeat (3) begin
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL mid_after got=%h exp=%h", obs, exp_v()); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0) begin reset_on(); reset_off(); end
            game_active = $urandom_range(0, 19) != 0;
            spawn_req = 4'($urandom & $urandom);
            shoot = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0;
            tick(); total++;
            if (obs !== exp_v()) begin bad++; $display("FAIL rand_cyc%0d got=%h exp=%h", c, obs, exp_v()); end
        end
    endtask

    initial begin
        Reset = 1'b1; game_active = 1'b0; spawn_req = '0; shoot = '0;
        model_reset();
        #12;
        test_reset();
        test_spawn_timeout();
        test_shoot_on_timeout();
        test_all_timeout();
        test_saturation();
        test_pause();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
